// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: mid-bit sampling UART receiver (8N1, or 8E1 with
// UART_RX_PARITY_EN) feeding a first-word-fall-through byte FIFO.
// in : clk, resetb (async, active low), rxd (async serial), rx_ready
// out: rx_data, rx_valid, rx_count, busy, frame_err, overrun,
//      parity_err (only when UART_RX_PARITY_EN is defined)
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 278,
  parameter int DEPTH        = 16
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     rxd,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     busy,
  output logic                     frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                     overrun,
  output logic                     parity_err
`else
  output logic                     overrun
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF =
    CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST =
    CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  state_t state, state_d;

  logic rxd_m, rxd_s;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic half_pt, bit_end, cnt_clr;
  logic push, ferr_d;

  logic [7:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic full, empty, pop, wr, ovr_d;

`ifdef UART_RX_PARITY_EN
  logic par_bad, stop_smp;
`endif

  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  assign half_pt = (cnt == HALF);
  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:
        if (!rxd_s) state_d = START;
      START:
        if (half_pt) state_d = rxd_s ? IDLE : DATA;
      DATA:
        if (bit_end && idx == 3'd7)
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
      PARITY:
        if (bit_end) state_d = STOP;
`else
          state_d = STOP;
`endif
      STOP:
        if (bit_end) state_d = rxd_s ? IDLE : BRK;
      BRK:
        if (rxd_s) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b1;
    push   = 1'b0;
    ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    stop_smp = 1'b0;
`endif
    unique case (state)
      IDLE: busy = 1'b0;
      STOP: begin
        push   = bit_end & rxd_s;
        ferr_d = bit_end & ~rxd_s;
`ifdef UART_RX_PARITY_EN
        stop_smp = bit_end;
`endif
      end
      default: ;
    endcase
  end

  // the counter restarts on every state change and every bit boundary
  assign cnt_clr = (state_d != state) | bit_end |
                   (state == IDLE) | (state == BRK);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cnt   <= '0;
      idx   <= 3'd0;
      shift <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == START && half_pt)
        idx <= 3'd0;
      if (state == DATA && bit_end) begin
        shift[idx] <= rxd_s;
        idx        <= idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      // even parity: data plus parity bit must xor to zero
      if (state == PARITY && bit_end)
        par_bad <= (^shift) ^ rxd_s;
`endif
    end
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ~empty & rx_ready;
  // a pop in the same cycle frees the slot being written
  assign wr    = push & (~full | pop);
  assign ovr_d = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[AW-1:0]] <= shift;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  assign rx_valid = ~empty;
  assign rx_data  = rx_valid ? mem[rptr[AW-1:0]] : 8'h00;
  assign rx_count = wptr - rptr;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err <= ferr_d;
      overrun   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_smp & par_bad;
`endif
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: randomized scoreboard bench for uart_rx_fifo.
// Frames are built bit by bit; a monitor checks every popped byte.
module tb_uart_rx_fifo;

  localparam int B     = 8;
  localparam int DEPTH = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // negedge index (from the start-bit edge) of the stop-sample cycle
  localparam int PUSH_NE = (NB - 1) * B + B / 2 + 2;

  logic       clk = 1'b0;
  logic       resetb;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [4:0] rx_count;
  logic       busy;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_fifo #(.CLKS_PER_BIT(B), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .busy      (busy),
    .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
    .overrun   (overrun),
    .parity_err(parity_err)
`else
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int exp_ovr, exp_perr;
  int ferr_cnt, ovr_cnt, perr_cnt, pop_cnt, busy_cnt, cnt_max;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input int act,
                       input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic clear_stats();
    exp_ovr  = 0;
    exp_perr = 0;
    ferr_cnt = 0;
    ovr_cnt  = 0;
    perr_cnt = 0;
    pop_cnt  = 0;
    busy_cnt = 0;
    cnt_max  = 0;
  endtask

  // monitor: samples mid-low-phase, well clear of both clock edges
  always @(negedge clk) begin
    #2;
    if (resetb) begin
      if (rx_valid && rx_ready) begin
        checks++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected: got %02h expected none",
                   rx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rx_data !== e) begin
            errors++;
            $display("FAIL rx_data: got %02h expected %02h",
                     rx_data, e);
          end
        end
      end
      if (frame_err) ferr_cnt++;
      if (overrun)   ovr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) perr_cnt++;
`endif
      if (busy) busy_cnt++;
      if (int'(rx_count) > cnt_max) cnt_max = int'(rx_count);
    end
  end

  always @(negedge clk) begin
    if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic fbit(input int k, input logic [7:0] b,
                                input logic p, input logic s);
    if (k == 0)       return 1'b0;
    else if (k <= 8)  return b[k-1];
    else if (k == NB - 1) return s;
    else              return p;
  endfunction

  // reference: a good stop bit delivers the byte unless the FIFO
  // already holds DEPTH bytes and nothing pops in the push cycle
  task automatic send(input logic [7:0] b, input logic s,
                      input logic pflip, input bit pop_pulse);
    logic p;
    p = (^b) ^ pflip;
    if (pflip && NB == 11) exp_perr++;
    if (s) begin
      if (!pop_pulse && exp_q.size() >= DEPTH) exp_ovr++;
      else exp_q.push_back(b);
    end
    for (int i = 0; i < NB * B; i++) begin
      @(negedge clk);
      rxd = fbit(i / B, b, p, s);
      if (pop_pulse && i == PUSH_NE) rx_ready = 1'b1;
      else if (pop_pulse && i == PUSH_NE + 1) rx_ready = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    rx_ready = 1'b1;
    n = 0;
    while ((rx_valid || exp_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    idle(2);
    check("drain_timeout", int'(n < 400), 1);
    check("drain_count", int'(rx_count), 0);
    check("drain_valid", int'(rx_valid), 0);
    check("drain_queue", exp_q.size(), 0);
    rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetb   = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    clear_stats();
    #23;
    check("rst_valid", int'(rx_valid), 0);
    check("rst_data", int'(rx_data), 0);
    check("rst_count", int'(rx_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ferr", int'(frame_err), 0);
    check("rst_ovr", int'(overrun), 0);
    @(negedge clk);
    resetb = 1'b1;
    idle(4);

    // back-to-back with ready held high
    clear_stats();
    rx_ready = 1'b1;
    send(8'h55, 1'b1, 1'b0, 1'b0);
    send(8'hA3, 1'b1, 1'b0, 1'b0);
    idle(6);
    check("b2b_pops", pop_cnt, 2);
    check("b2b_cnt_max_le1", int'(cnt_max <= 1), 1);
    check("b2b_ferr", ferr_cnt, 0);
    check("b2b_ovr", ovr_cnt, exp_ovr);
    rx_ready = 1'b0;

    // start-bit glitch of two clocks
    idle(4);
    clear_stats();
    @(negedge clk) rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(12);
    check("glitch_busy_about4",
          int'(busy_cnt >= 3 && busy_cnt <= 5), 1);
    check("glitch_valid", int'(rx_valid), 0);
    check("glitch_ferr", ferr_cnt, 0);
    check("glitch_ovr", ovr_cnt, 0);

    // bad stop bit, then line held low
    clear_stats();
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(3 * B);
    check("brk_busy_held", int'(busy), 1);
    rxd = 1'b1;
    idle(6);
    check("brk_busy_rel", int'(busy), 0);
    check("brk_ferr", ferr_cnt, 1);
    check("brk_valid", int'(rx_valid), 0);
    rx_ready = 1'b1;
    send(8'h81, 1'b1, 1'b0, 1'b0);
    idle(6);
    check("brk_next_pops", pop_cnt, 1);
    rx_ready = 1'b0;

    // fill past DEPTH with no consumer
    clear_stats();
    for (int i = 0; i <= DEPTH; i++)
      send(8'(i), 1'b1, 1'b0, 1'b0);
    idle(4);
    check("full_count", int'(rx_count), DEPTH);
    check("full_ovr", ovr_cnt, exp_ovr);
    check("full_ovr_one", ovr_cnt, 1);
    drain();

    // pop in the very cycle the 17th byte is pushed
    clear_stats();
    for (int i = 0; i < DEPTH; i++)
      send(8'(i), 1'b1, 1'b0, 1'b0);
    send(8'h10, 1'b1, 1'b0, 1'b1);
    idle(4);
    check("pp_ovr", ovr_cnt, 0);
    check("pp_count", int'(rx_count), DEPTH);
    drain();
    check("pp_pops", pop_cnt, DEPTH + 1);

    // random bytes with a randomly stalling consumer
    clear_stats();
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      send(8'($urandom), 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 20));
    end
    rand_ready = 1'b0;
    drain();
    check("rand_pops", pop_cnt, 24);
    check("rand_ovr", ovr_cnt, exp_ovr);
    check("rand_ferr", ferr_cnt, 0);

`ifdef UART_RX_PARITY_EN
    clear_stats();
    rx_ready = 1'b1;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    idle(6);
    check("par_bad_err", perr_cnt, exp_perr);
    check("par_bad_one", perr_cnt, 1);
    check("par_bad_pops", pop_cnt, 1);
    clear_stats();
    send(8'h07, 1'b1, 1'b0, 1'b0);
    idle(6);
    check("par_ok_err", perr_cnt, 0);
    check("par_ok_pops", pop_cnt, 1);
    rx_ready = 1'b0;
`endif

    // reset in the middle of a frame with data queued
    clear_stats();
    send(8'h11, 1'b1, 1'b0, 1'b0);
    send(8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk) rxd = 1'b0;
    idle(3 * B);
    #3 resetb = 1'b0;
    #1;
    check("mid_rst_valid", int'(rx_valid), 0);
    check("mid_rst_count", int'(rx_count), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_data", int'(rx_data), 0);
    check("mid_rst_ferr", int'(frame_err), 0);
    check("mid_rst_ovr", int'(overrun), 0);
`ifdef UART_RX_PARITY_EN
    check("mid_rst_perr", int'(parity_err), 0);
`endif
    exp_q.delete();
    rxd = 1'b1;
    idle(3);
    resetb = 1'b1;
    idle(4);
    check("post_rst_busy", int'(busy), 0);
    clear_stats();
    rx_ready = 1'b1;
    send(8'hC6, 1'b1, 1'b0, 1'b0);
    idle(6);
    check("post_rst_pops", pop_cnt, 1);
    check("final_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
